seq_cla_adder: RTL

SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

---
 rtl/seq_cla_adder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_cla_adder.sv
// Purpose: sequential adder/subtractor, one 4-bit carry-lookahead group per cycle.
// Latency: start at edge k -> busy for cycles k+1..k+NG, done pulse in cycle k+NG+1.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
module seq_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             p,
    output logic             g,
    output logic             busy,
    output logic             done
);

    localparam int NG = WIDTH / 4;
    localparam int IW = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Operands are captured at start so later input changes cannot disturb the result.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             pacc;
    logic             gacc;

    logic [3:0]       ga;
    logic [3:0]       gb;
    logic [3:0]       bp;
    logic [3:0]       bg;
    logic [3:0]       gs;
    logic [4:0]       c;
    logic             grp_p;
    logic             grp_g;
    logic             last;

    // 4-bit carry-lookahead over the group currently selected by idx.
    always_comb begin
        ga    = a_r[{idx, 2'b00} +: 4];
        gb    = b_r[{idx, 2'b00} +: 4];
        bp    = ga ^ gb;
        bg    = ga & gb;
        c[0]  = carry;
        c[1]  = bg[0] | (bp[0] & c[0]);
        c[2]  = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & c[0]);
        c[3]  = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
              | (bp[2] & bp[1] & bp[0] & c[0]);
        grp_p = &bp;
        grp_g = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
              | (bp[3] & bp[2] & bp[1] & bg[0]);
        c[4]  = grp_g | (grp_p & c[0]);
        gs    = bp ^ c[3:0];
        last  = (idx == IW'(NG - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; DONE always returns to IDLE after one cycle.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture on start, then ripple one group per cycle through the carry register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            pacc  <= 1'b0;
            gacc  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            p     <= 1'b0;
            g     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        pacc  <= 1'b1;
                        gacc  <= 1'b0;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= gs;
                    carry <= c[4];
                    pacc  <= grp_p & pacc;
                    gacc  <= grp_g | (grp_p & gacc);
                    idx   <= idx + 1'b1;
                    // Word-level flags only change once the MSB group is resolved.
                    if (last) begin
                        cout <= c[4];
                        ovf  <= c[3] ^ c[4];
                        p    <= grp_p & pacc;
                        g    <= grp_g | (grp_p & gacc);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
